instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Byte-stream writer for the instruction memory: fills program memory at run time instead of $readmemh.
//  Takes bytes from a UART receiver (rx_valid_i pulse per byte) and checks a 16-bit word-count header.
//  Assembles little-endian 32-bit words and issues one write per word to the instr memory write port.
//  Holds the CPU core in reset while loading; sits between uart_rx and the instr memory write side.
// PARAMETERS
//  MEM_WORDS    1024     capacity of instr memory in 32-bit words; max accepted length
//  TIMEOUT_CYC  1000000  max idle cycles between bytes while loading before abort
// PORTS
//  clk_i        in   1   system clock
//  rst_i        in   1   asynchronous reset, active-low
//  start_i      in   1   single-cycle pulse: arm loader (honoured only in IDLE or ERR)
//  rx_data_i    in   8   received byte
//  rx_valid_i   in   1   single-cycle pulse: rx_data_i valid
//  mem_we_o     out  1   instr memory write enable, one cycle per word
//  mem_addr_o   out  32  byte address of write, word aligned (word_idx<<2)
//  mem_wd_o     out  32  write data word
//  busy_o       out  1   loader active (LEN_LO, LEN_HI, DATA, WRITE)
//  core_rst_o   out  1   hold CPU in reset; equals busy_o
//  done_o       out  1   single-cycle pulse: all words written
//  err_o        out  1   sticky error flag; cleared by start_i
// BEHAVIOUR
//  Reset (rst_i=0, any time, async): state=IDLE, all outputs 0, counters/buffers 0.
//  Words already written are not undone.
//  Frame: LEN[7:0], LEN[15:8], then LEN*4 data bytes, b0 = word[7:0] ... b3 = word[31:24].
//  FSM:
//   IDLE   : start_i -> LEN_LO. rx_valid_i ignored.
//   LEN_LO : rx_valid_i -> len[7:0]=byte, -> LEN_HI.
//   LEN_HI : rx_valid_i -> len[15:8]=byte.
//            If {byte,len[7:0]}==0 or >MEM_WORDS -> ERR; else -> DATA, byte_cnt=0, word_idx=0.
//   DATA   : rx_valid_i -> buf[8*byte_cnt +: 8]=byte, byte_cnt++ (2-bit, wraps).
//            On 4th byte -> WRITE.
//   WRITE  : exactly 1 cycle; mem_we_o=1, mem_addr_o=word_idx<<2, mem_wd_o=buf.
//            Then word_idx++; if word_idx+1==len -> DONE else -> DATA.
//            rx_valid_i in WRITE = overrun -> ERR (no byte stored).
//   DONE   : done_o=1 for this one cycle -> IDLE.
//   ERR    : err_o=1 held; mem_we_o=0; start_i -> LEN_LO, err_o cleared same edge.
//  Timeout: cycle counter cleared on every rx_valid_i and on entry to LEN_LO.
//   Counts in LEN_LO/LEN_HI/DATA; reaching TIMEOUT_CYC -> ERR.
//  start_i while busy_o=1: ignored.
//  Simultaneous start_i and rx_valid_i in IDLE: go to LEN_LO; the byte is dropped.
//  Outputs registered; mem_we_o/mem_addr_o/mem_wd_o valid only while mem_we_o=1, else addr/wd hold last.
//  Latency: mem_we_o asserts the cycle after the edge sampling the 4th byte of a word.
// TESTING
//  1. Reset, start, bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr 0x0 = 0x00000013.
//     Then addr 0x4 = 0x00100093, then done_o pulse; busy_o low after.
//  2. start, LEN 00 00 -> err_o=1, no mem_we_o.
//     Then start, LEN 01 00, 4 bytes -> err_o cleared, 1 write.
//  3. start, LEN 01 04 (1025 > MEM_WORDS) -> err_o=1.
//     LEN 00 04 (1024) accepted; last write addr 0xFFC.
//  4. start, LEN 01 00, 2 bytes, then silence TIMEOUT_CYC (set 50) cycles -> err_o=1, busy_o=0, no write.
//  5. rx_valid_i asserted in the WRITE cycle -> err_o=1, that write still completes.
//     Separately: rst_i low mid-DATA -> all outputs 0 immediately, IDLE.
//  6. Bytes sent in IDLE without start_i -> no writes, busy_o stays 0.
//     start_i during DATA -> no effect on word_idx/addresses.

Source files
------------

// File: rtl/instr_loader.sv
// Loads the instruction memory from a UART byte stream: 16-bit word-count header,
// then little-endian 32-bit words, one memory write per word. Holds the core in reset meanwhile.
module instr_loader #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        busy_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   len_new;
  logic          tmo_hit;

  assign len_new = {rx_data_i, len_q[7:0]};
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    wd_d       = wd_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LEN_LO;
          tmo_d   = '0;
        end
      end
      LEN_LO: begin
        if (rx_valid_i) begin
          len_d[7:0] = rx_data_i;
          tmo_d      = '0;
          state_d    = LEN_HI;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      LEN_HI: begin
        if (rx_valid_i) begin
          len_d = len_new;
          tmo_d = '0;
          if (len_new == 16'd0 || 32'(len_new) > MEM_WORDS) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            byte_cnt_d = '0;
            word_idx_d = '0;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_valid_i) begin
          buf_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_d      = '0;
          if (byte_cnt_q == 2'd3) begin
            // Write port is loaded directly so the word appears the cycle after its last byte.
            state_d = WRITE;
            addr_d  = {14'd0, word_idx_q, 2'b00};
            wd_d    = {rx_data_i, buf_q[23:0]};
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (rx_valid_i)                       state_d = ERR;
        else if (word_idx_q + 16'd1 == len_q) state_d = DONE;
        else                                  state_d = DATA;
      end
      DONE: state_d = IDLE;
      ERR: begin
        if (start_i) begin
          state_d = LEN_LO;
          tmo_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_we_d = (state_d == WRITE);
    busy_d   = (state_d == LEN_LO) || (state_d == LEN_HI) ||
               (state_d == DATA)   || (state_d == WRITE);
    done_d   = (state_d == DONE);
    err_d    = (state_d == ERR);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      wd_q       <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;
  assign busy_o     = busy_q;
  assign core_rst_o = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued by the stimulus,
// a negedge monitor pops and compares them whenever mem_we_o is seen.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        busy, core_rst, done, err;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb_q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  done_cnt = 0;

  instr_loader #(.MEM_WORDS(1024), .TIMEOUT_CYC(50)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wd_o   (mem_wd),
    .busy_o     (busy),
    .core_rst_o (core_rst),
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wd);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wd, e.d);
      end
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int exp);
    for (int i = 0; i < 40 && done_cnt < exp; i++) @(negedge clk);
    chk("done_count", done_cnt, exp);
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two-word load
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_core_rst", {31'd0, core_rst}, 32'd1);
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'h0010_0093);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_done(1);
    chk("t1_core_rst_low", {31'd0, core_rst}, 32'd0);

    // 2: zero length is an error; restart clears it
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    repeat (2) @(negedge clk);
    chk("t2_err_zero_len", {31'd0, err}, 32'd1);
    chk("t2_busy_in_err", {31'd0, busy}, 32'd0);
    pulse_start();
    chk("t2_err_cleared", {31'd0, err}, 32'd0);
    chk("t2_busy_restart", {31'd0, busy}, 32'd1);
    push_wr(32'h0, 32'hDEAD_BEEF);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_done(2);
    chk("t2_err_after", {31'd0, err}, 32'd0);

    // 3: length boundary 1025 rejected, 1024 accepted
    pulse_start();
    send_byte(8'h01); send_byte(8'h04);
    repeat (2) @(negedge clk);
    chk("t3_err_1025", {31'd0, err}, 32'd1);
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 1024; i++) begin
      w = 32'hA500_0000 | 32'(i);
      push_wr(32'(i) << 2, w);
      send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
    end
    wait_done(3);
    chk("t3_last_addr", mem_addr, 32'h0000_0FFC);
    chk("t3_last_data", mem_wd, 32'hA500_03FF);
    chk("t3_err_1024", {31'd0, err}, 32'd0);

    // 4: timeout after 50 silent cycles, not before
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    repeat (40) @(negedge clk);
    chk("t4_no_early_tmo", {31'd0, err}, 32'd0);
    chk("t4_busy_waiting", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_err_tmo", {31'd0, err}, 32'd1);
    chk("t4_busy_tmo", {31'd0, busy}, 32'd0);

    // 5: byte during WRITE is an overrun; the write still lands
    pulse_start();
    push_wr(32'h0, 32'h4433_2211);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rx_data = 8'h44; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h55;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_err_overrun", {31'd0, err}, 32'd1);
    chk("t5_busy_overrun", {31'd0, busy}, 32'd0);

    // 5b: async reset mid-DATA
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    chk("t5_busy_pre_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_core_rst", {31'd0, core_rst}, 32'd0);
    chk("t5_rst_wd", mem_wd, 32'd0);
    chk("t5_rst_err", {31'd0, err}, 32'd0);
    chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: bytes without start are ignored; start mid-load has no effect
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    push_wr(32'h0, 32'h0403_0201);
    push_wr(32'h4, 32'h0807_0605);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
    pulse_start();
    send_byte(8'h07); send_byte(8'h08);
    wait_done(4);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("final_done_count", done_cnt, 32'd4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
